// File: rtl/align_pkg.sv
// Shared types and widths for the aligner lock controller.
package align_pkg;

  localparam int unsigned OFFSET_W   = 7;
  localparam int unsigned MAX_OFFSET = 65;
  localparam int unsigned HIT_W      = 8;
  localparam int unsigned MISS_W     = 8;
  localparam int unsigned TO_W       = 16;

  typedef enum logic [1:0] {
    ST_RESEEK,
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED
  } align_state_t;

endpackage

// File: rtl/aligner_lock_ctrl_if.sv
// Seeker-tree side of the aligner lock controller: frame reports in, seeker reset out.
interface aligner_lock_ctrl_if;
  import align_pkg::*;

  logic                buffer_dv;
  logic                is_synced;
  logic [OFFSET_W-1:0] offset_pos;
  logic                seeker_rst_o;

  modport master (
    output buffer_dv, is_synced, offset_pos,
    input  seeker_rst_o
  );

  modport slave (
    input  buffer_dv, is_synced, offset_pos,
    output seeker_rst_o
  );

endinterface

// File: rtl/align_frame_cnt.sv
// Saturating frame counter; clr together with inc loads 1 rather than 0.
module align_frame_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aligner_lock_ctrl.sv
// Frame-alignment lock FSM (RESEEK/SEARCH/CONFIRM/LOCKED) driving the seeker tree.
// Define ALIGN_LOCK_TIMEOUT_EN to force a reseek after TIMEOUT_FRAMES unsynced frames in SEARCH.
module aligner_lock_ctrl
  import align_pkg::*;
#(
  parameter int unsigned LOCK_CNT       = 32,
  parameter int unsigned UNLOCK_CNT     = 8,
  parameter int unsigned TIMEOUT_FRAMES = 1024,
  parameter int unsigned RESEEK_CYC     = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  aligner_lock_ctrl_if.slave  seek,
  output logic                locked_o,
  output logic [OFFSET_W-1:0] offset_o,
  output logic [7:0]          relock_cnt_o
);

  if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("LOCK_CNT out of range 1..255");
  end
  if (UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_bad_unlock_cnt
    $error("UNLOCK_CNT out of range 1..255");
  end
  if (TIMEOUT_FRAMES < 2 || TIMEOUT_FRAMES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_FRAMES out of range 2..65535");
  end
  if (RESEEK_CYC < 1 || RESEEK_CYC > 15) begin : g_bad_reseek
    $error("RESEEK_CYC out of range 1..15");
  end

  align_state_t        state;
  logic [OFFSET_W-1:0] cand;
  logic [3:0]          reseek_cnt;
  logic                seeker_rst_q;
  logic [HIT_W-1:0]    hit_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  logic dv, synced;
  logic [OFFSET_W-1:0] pos;
  logic cand_match, lock_match;
  logic hit_clr, hit_inc, miss_clr, miss_inc;
  logic hit_last, miss_last, timeout_hit;

  assign dv     = seek.buffer_dv;
  assign synced = seek.is_synced;
  assign pos    = seek.offset_pos;
  assign seek.seeker_rst_o = seeker_rst_q;

  always_comb begin
    cand_match = synced && (pos == cand);
    lock_match = synced && (pos == offset_o);
    // A SEARCH capture is clr+inc, which loads hit_cnt with 1.
    hit_clr  = (state == ST_RESEEK)
            || (state == ST_SEARCH  && dv && synced)
            || (state == ST_CONFIRM && dv && !cand_match);
    hit_inc  = dv && ((state == ST_SEARCH && synced) || (state == ST_CONFIRM && cand_match));
    miss_clr = (state == ST_RESEEK) || (state == ST_LOCKED && dv && lock_match);
    miss_inc = (state == ST_LOCKED) && dv && !lock_match;
    hit_last  = (hit_cnt  == HIT_W'(LOCK_CNT - 1));
    miss_last = (miss_cnt == MISS_W'(UNLOCK_CNT - 1));
  end

  align_frame_cnt #(.W(HIT_W)) u_hit_cnt (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr (hit_clr), .inc (hit_inc), .cnt (hit_cnt)
  );

  align_frame_cnt #(.W(MISS_W)) u_miss_cnt (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr (miss_clr), .inc (miss_inc), .cnt (miss_cnt)
  );

`ifdef ALIGN_LOCK_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_clr, to_inc;

  assign to_clr      = (state == ST_RESEEK);
  assign to_inc      = (state == ST_SEARCH) && dv && !synced;
  assign timeout_hit = to_inc && (to_cnt == TO_W'(TIMEOUT_FRAMES - 1));

  align_frame_cnt #(.W(TO_W)) u_to_cnt (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr (to_clr), .inc (to_inc), .cnt (to_cnt)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_RESEEK;
      seeker_rst_q <= 1'b1;
      reseek_cnt   <= '0;
      locked_o     <= 1'b0;
      offset_o     <= '0;
      cand         <= '0;
      relock_cnt_o <= '0;
    end else begin
      unique case (state)
        ST_RESEEK: begin
          if (reseek_cnt == 4'(RESEEK_CYC - 1)) begin
            state        <= ST_SEARCH;
            seeker_rst_q <= 1'b0;
            reseek_cnt   <= '0;
          end else begin
            reseek_cnt <= reseek_cnt + 1'b1;
          end
        end
        ST_SEARCH: begin
          if (dv && synced) begin
            cand <= pos;
            if (LOCK_CNT == 1) begin
              state    <= ST_LOCKED;
              locked_o <= 1'b1;
              offset_o <= pos;
            end else begin
              state <= ST_CONFIRM;
            end
          end else if (timeout_hit) begin
            state        <= ST_RESEEK;
            seeker_rst_q <= 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (dv) begin
            if (!cand_match) begin
              state <= ST_SEARCH;
            end else if (hit_last) begin
              state    <= ST_LOCKED;
              locked_o <= 1'b1;
              offset_o <= cand;
            end
          end
        end
        ST_LOCKED: begin
          if (miss_inc && miss_last) begin
            state        <= ST_RESEEK;
            seeker_rst_q <= 1'b1;
            locked_o     <= 1'b0;
            if (relock_cnt_o != '1) relock_cnt_o <= relock_cnt_o + 1'b1;
          end
        end
        default: state <= ST_RESEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_aligner_lock_ctrl.sv
// Scoreboard bench for aligner_lock_ctrl; timeout expectations follow ALIGN_LOCK_TIMEOUT_EN.
module tb_aligner_lock_ctrl;
  import align_pkg::*;

  localparam int unsigned LOCK_CNT       = 4;
  localparam int unsigned UNLOCK_CNT     = 3;
  localparam int unsigned TIMEOUT_FRAMES = 16;
  localparam int unsigned RESEEK_CYC     = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                locked_o;
  logic [OFFSET_W-1:0] offset_o;
  logic [7:0]          relock_cnt_o;

  aligner_lock_ctrl_if seek_if ();

  aligner_lock_ctrl #(
    .LOCK_CNT       (LOCK_CNT),
    .UNLOCK_CNT     (UNLOCK_CNT),
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
    .RESEEK_CYC     (RESEEK_CYC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .seek         (seek_if),
    .locked_o     (locked_o),
    .offset_o     (offset_o),
    .relock_cnt_o (relock_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic                lock;
    logic [OFFSET_W-1:0] off;
    logic [7:0]          rel;
    logic                srst;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_rel = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // One clock: push expectation, drive frame, compare after the edge.
  task automatic frame(input string tag, input logic dv, input logic sync,
                       input logic [OFFSET_W-1:0] off, input logic e_lock,
                       input logic [OFFSET_W-1:0] e_off, input logic e_srst);
    exp_t e;
    e.lock = e_lock; e.off = e_off; e.rel = exp_rel; e.srst = e_srst;
    sb.push_back(e);
    seek_if.buffer_dv  = dv;
    seek_if.is_synced  = sync;
    seek_if.offset_pos = off;
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check({tag, ".lock"}, 32'(locked_o), 32'(e.lock));
    if (e.lock) check({tag, ".off"}, 32'(offset_o), 32'(e.off));
    check({tag, ".rel"}, 32'(relock_cnt_o), 32'(e.rel));
    check({tag, ".srst"}, 32'(seek_if.seeker_rst_o), 32'(e.srst));
    seek_if.buffer_dv = 1'b0;
    seek_if.is_synced = 1'b0;
  endtask

  task automatic lock_at(input string tag, input logic [OFFSET_W-1:0] off);
    for (int i = 0; i < 3; i++) frame(tag, 1'b1, 1'b1, off, 1'b0, '0, 1'b0);
    frame({tag, ".lk"}, 1'b1, 1'b1, off, 1'b1, off, 1'b0);
  endtask

  task automatic unlock3(input string tag, input logic [OFFSET_W-1:0] off);
    frame(tag, 1'b1, 1'b0, '0, 1'b1, off, 1'b0);
    frame(tag, 1'b1, 1'b0, '0, 1'b1, off, 1'b0);
    exp_rel = (exp_rel == 8'hFF) ? 8'hFF : exp_rel + 8'd1;
    frame({tag, ".ul"}, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    frame({tag, ".rs1"}, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    frame({tag, ".rs2"}, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_ni             = 1'b0;
    seek_if.buffer_dv  = 1'b0;
    seek_if.is_synced  = 1'b0;
    seek_if.offset_pos = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.srst", 32'(seek_if.seeker_rst_o), 32'd1);
    check("rst.lock", 32'(locked_o), 32'd0);
    check("rst.off",  32'(offset_o), 32'd0);
    check("rst.rel",  32'(relock_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    frame("rel1", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    frame("rel2", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    // Lock at 37 with an idle cycle between frames 2 and 3.
    frame("l37a", 1'b1, 1'b1, 7'd37, 1'b0, '0, 1'b0);
    frame("l37b", 1'b1, 1'b1, 7'd37, 1'b0, '0, 1'b0);
    frame("l37i", 1'b0, 1'b0, 7'd37, 1'b0, '0, 1'b0);
    frame("l37c", 1'b1, 1'b1, 7'd37, 1'b0, '0, 1'b0);
    frame("l37d", 1'b1, 1'b1, 7'd37, 1'b1, 7'd37, 1'b0);

    // miss, good, miss, miss, miss -> unlock on 5th frame.
    frame("m1", 1'b1, 1'b0, 7'd37, 1'b1, 7'd37, 1'b0);
    frame("g1", 1'b1, 1'b1, 7'd37, 1'b1, 7'd37, 1'b0);
    frame("m2", 1'b1, 1'b1, 7'd12, 1'b1, 7'd37, 1'b0);
    frame("m3", 1'b1, 1'b0, 7'd37, 1'b1, 7'd37, 1'b0);
    exp_rel = 8'd1;
    frame("m4", 1'b1, 1'b0, 7'd37, 1'b0, '0, 1'b1);
    frame("rsdv", 1'b1, 1'b1, 7'd12, 1'b0, '0, 1'b1);
    frame("rsend", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    frame("c37a", 1'b1, 1'b1, 7'd37, 1'b0, '0, 1'b0);
    frame("c37b", 1'b1, 1'b1, 7'd37, 1'b0, '0, 1'b0);
    frame("c12x", 1'b1, 1'b1, 7'd12, 1'b0, '0, 1'b0);
    lock_at("c12", 7'd12);
    unlock3("u12", 7'd12);

`ifdef ALIGN_LOCK_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      frame("to", 1'b1, 1'b0, '0, 1'b0, '0, (i == 15) ? 1'b1 : 1'b0);
    frame("to.rs1", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    frame("to.rs2", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
`else
    for (int i = 0; i < 100; i++)
      frame("noto", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
`endif
    lock_at("l20", 7'd20);

    for (int i = 0; i < 300; i++) begin
      unlock3("sat.u", (i == 0) ? 7'd20 : 7'((i - 1) % 66));
      lock_at("sat.l", 7'(i % 66));
    end
    check("sat.final", 32'(relock_cnt_o), 32'd255);

    #3;
    rst_ni = 1'b0;
    #1;
    check("arst.lock", 32'(locked_o), 32'd0);
    check("arst.rel",  32'(relock_cnt_o), 32'd0);
    check("arst.srst", 32'(seek_if.seeker_rst_o), 32'd1);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    exp_rel = '0;
    frame("arst.rs1", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    frame("arst.rs2", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    lock_at("l50", 7'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
